multicycle_cpu_core: RTL and testbench

Parametrised multi-cycle successor to the single-cycle 16-bit datapath. It runs the same 16-bit instruction format through an explicit fetch/decode/execute/memory/writeback state machine. Instruction fetch and data access share one handshaked memory port, and data width, PC width and reset vector are configurable. It sits between the top level and a unified memory model and exposes retire/halt status for the bench.

---
 rtl/multicycle_cpu_core.sv | 181 ++++++++++++++++++
 tb/tb_multicycle_cpu_core.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_cpu_core.sv
// Multi-cycle 16-bit-instruction CPU core: FETCH/DECODE/EXEC/MEM/WB sequencing
// over a single handshaked memory port shared by instruction and data traffic.
module multicycle_cpu_core #(
  parameter int               DSIZE    = 16,
  parameter int               PSIZE    = 16,
  parameter logic [PSIZE-1:0] RESET_PC = {PSIZE{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  output logic             mem_req,
  output logic             mem_we,
  output logic [PSIZE-1:0] mem_addr,
  output logic [DSIZE-1:0] mem_wdata,
  input  logic [DSIZE-1:0] mem_rdata,
  input  logic             mem_ready,
  output logic [PSIZE-1:0] pc,
  output logic             retire,
  output logic             halted
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SLL  = 4'h5;
  localparam logic [3:0] OP_SRL  = 4'h6;
  localparam logic [3:0] OP_LW   = 4'h8;
  localparam logic [3:0] OP_SW   = 4'h9;
  localparam logic [3:0] OP_BEQ  = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [PSIZE-1:0] PC_ONE   = PSIZE'(1'b1);
  localparam logic [PSIZE-1:0] JMP_MASK = PSIZE'(12'hFFF);

  state_t             state_r;
  state_t             state_nxt_s;
  logic [15:0]        ir_r;
  logic [PSIZE-1:0]   pc_r;
  logic [PSIZE-1:0]   addr_r;
  logic [DSIZE-1:0]   a_r;
  logic [DSIZE-1:0]   b_r;
  logic [DSIZE-1:0]   simm_r;
  logic [DSIZE-1:0]   alu_r;
  logic [DSIZE-1:0]   mdr_r;
  logic               halt_seen_r;
  logic [DSIZE-1:0]   rf_r [16];

  logic [3:0]         op_s;
  logic [3:0]         rd_s;
  logic [3:0]         rs_s;
  logic [3:0]         rt_s;
  logic [DSIZE-1:0]   simm_s;
  logic [PSIZE-1:0]   psimm_s;
  logic [PSIZE-1:0]   pc_jmp_s;
  logic [DSIZE-1:0]   alu_s;
  logic               exec_retire_s;

  assign op_s     = ir_r[15:12];
  assign rd_s     = ir_r[11:8];
  assign rs_s     = ir_r[7:4];
  assign rt_s     = ir_r[3:0];
  assign simm_s   = {{(DSIZE-4){ir_r[3]}}, ir_r[3:0]};
  assign psimm_s  = {{(PSIZE-4){ir_r[3]}}, ir_r[3:0]};
  assign pc_jmp_s = (pc_r & ~JMP_MASK) | PSIZE'(ir_r[11:0]);

  // ALU; ADDI and the LW/SW effective address share the add-immediate path
  always_comb begin
    alu_s = a_r + simm_r;
    case (op_s)
      OP_ADD:  alu_s = a_r + b_r;
      OP_SUB:  alu_s = a_r - b_r;
      OP_AND:  alu_s = a_r & b_r;
      OP_OR:   alu_s = a_r | b_r;
      OP_XOR:  alu_s = a_r ^ b_r;
      OP_SLL:  alu_s = a_r << rt_s;
      OP_SRL:  alu_s = a_r >> rt_s;
      default: alu_s = a_r + simm_r;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_FETCH: begin
        if (mem_ready) state_nxt_s = S_DECODE;
        else           state_nxt_s = S_FETCH;
      end
      S_DECODE: begin
        if (op_s == OP_HALT) state_nxt_s = S_HALT;
        else                 state_nxt_s = S_EXEC;
      end
      S_EXEC: begin
        if (op_s[3] == 1'b0)                        state_nxt_s = S_WB;
        else if ((op_s == OP_LW) || (op_s == OP_SW)) state_nxt_s = S_MEM;
        else                                         state_nxt_s = S_FETCH;
      end
      S_MEM: begin
        if (!mem_ready)          state_nxt_s = S_MEM;
        else if (op_s == OP_LW)  state_nxt_s = S_WB;
        else                     state_nxt_s = S_FETCH;
      end
      S_WB:    state_nxt_s = S_FETCH;
      S_HALT:  state_nxt_s = S_HALT;
      default: state_nxt_s = S_FETCH;
    endcase
  end

  // Branch, jump and NOP finish in EXEC
  assign exec_retire_s = op_s[3] && (op_s != OP_LW) && (op_s != OP_SW);

  assign mem_req   = (state_r == S_FETCH) || (state_r == S_MEM);
  assign mem_we    = (state_r == S_MEM) && (op_s == OP_SW);
  assign mem_addr  = (state_r == S_MEM) ? addr_r : pc_r;
  assign mem_wdata = b_r;
  assign pc        = pc_r;
  assign halted    = (state_r == S_HALT);
  assign retire    = (state_r == S_WB)
                   || ((state_r == S_EXEC) && exec_retire_s)
                   || ((state_r == S_MEM) && mem_ready && (op_s == OP_SW))
                   || ((state_r == S_HALT) && !halt_seen_r);

  // State, datapath registers and register file
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_FETCH;
      pc_r        <= RESET_PC;
      ir_r        <= 16'h0000;
      addr_r      <= {PSIZE{1'b0}};
      a_r         <= {DSIZE{1'b0}};
      b_r         <= {DSIZE{1'b0}};
      simm_r      <= {DSIZE{1'b0}};
      alu_r       <= {DSIZE{1'b0}};
      mdr_r       <= {DSIZE{1'b0}};
      halt_seen_r <= 1'b0;
      for (int i = 0; i < 16; i++) rf_r[i] <= {DSIZE{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        S_FETCH: begin
          if (mem_ready) begin
            ir_r <= mem_rdata[15:0];
            pc_r <= pc_r + PC_ONE;
          end
        end
        S_DECODE: begin
          a_r    <= rf_r[rs_s];
          b_r    <= ((op_s == OP_SW) || (op_s == OP_BEQ)) ? rf_r[rd_s] : rf_r[rt_s];
          simm_r <= simm_s;
        end
        S_EXEC: begin
          alu_r  <= alu_s;
          addr_r <= PSIZE'(alu_s);
          // pc_r already points past the branch, so the target is pc_r + simm
          if ((op_s == OP_BEQ) && (a_r == b_r)) pc_r <= pc_r + psimm_s;
          else if (op_s == OP_JMP)               pc_r <= pc_jmp_s;
        end
        S_MEM: begin
          if (mem_ready && (op_s == OP_LW)) mdr_r <= mem_rdata;
        end
        S_WB: begin
          if (rd_s != 4'h0) rf_r[rd_s] <= (op_s == OP_LW) ? mdr_r : alu_r;
        end
        S_HALT:  halt_seen_r <= 1'b1;
        default: halt_seen_r <= halt_seen_r;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_cpu_core.sv
// Self-checking bench for multicycle_cpu_core: table-driven ALU vectors on a
// 16-bit core plus hand sequences for memory stalls, branches, halt and reset.
module tb_multicycle_cpu_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  logic        a_req, a_we, a_ready, a_retire, a_halted;
  logic [15:0] a_addr, a_wdata, a_rdata, a_pc;
  logic        b_req, b_we, b_ready, b_retire, b_halted;
  logic [15:0] b_addr, b_pc;
  logic [31:0] b_wdata, b_rdata;

  logic [15:0] mem_a [4096];
  logic [31:0] mem_b [4096];
  logic        ld_a_en = 1'b0, ld_b_en = 1'b0;
  logic [11:0] ld_addr = 12'h000;
  logic [15:0] ld_a_data = 16'h0000;
  logic [31:0] ld_b_data = 32'h0;
  int          wait_cfg = 0;
  int          stall_cnt = 0;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          ret_q[$];
  logic [15:0] fetch_q[$];

  multicycle_cpu_core #(.DSIZE(16), .PSIZE(16), .RESET_PC(16'h0010)) dut_a (
    .clk(clk), .rst(rst), .mem_req(a_req), .mem_we(a_we), .mem_addr(a_addr),
    .mem_wdata(a_wdata), .mem_rdata(a_rdata), .mem_ready(a_ready),
    .pc(a_pc), .retire(a_retire), .halted(a_halted));

  multicycle_cpu_core #(.DSIZE(32), .PSIZE(16), .RESET_PC(16'h0100)) dut_b (
    .clk(clk), .rst(rst), .mem_req(b_req), .mem_we(b_we), .mem_addr(b_addr),
    .mem_wdata(b_wdata), .mem_rdata(b_rdata), .mem_ready(b_ready),
    .pc(b_pc), .retire(b_retire), .halted(b_halted));

  assign a_ready = a_req && (stall_cnt >= wait_cfg);
  assign a_rdata = mem_a[a_addr[11:0]];
  assign b_ready = b_req;
  assign b_rdata = mem_b[b_addr[11:0]];

  // Memory models with wait-state insertion on the 16-bit core's port
  always @(posedge clk) begin
    if (ld_a_en) mem_a[ld_addr] <= ld_a_data;
    else if (a_req && a_we && a_ready) mem_a[a_addr[11:0]] <= a_wdata;
    if (ld_b_en) mem_b[ld_addr] <= ld_b_data;
    else if (b_req && b_we && b_ready) mem_b[b_addr[11:0]] <= b_wdata;
    if (rst || !a_req || a_ready) stall_cnt <= 0;
    else stall_cnt <= stall_cnt + 1;
  end

  // Retire-cycle and fetch-address logs, cleared by reset
  always @(negedge clk) begin
    if (rst) begin
      cyc <= 0;
      ret_q.delete();
      fetch_q.delete();
    end else begin
      cyc <= cyc + 1;
      if (a_retire) ret_q.push_back(cyc);
      if (a_req && !a_we && a_ready) fetch_q.push_back(a_addr);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_ret_gap(input string nm, input int i, input int exp);
    if (i >= 1 && i < ret_q.size()) chk(nm, ret_q[i] - ret_q[i-1], exp);
    else begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: only %0d retires logged, need index %0d", nm, ret_q.size(), i);
    end
  endtask

  task automatic chk_fetch(input string nm, input int i, input logic [15:0] exp);
    if (i < fetch_q.size()) chk(nm, fetch_q[i], exp);
    else begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: only %0d fetches logged, need index %0d", nm, fetch_q.size(), i);
    end
  endtask

  task automatic load_a(input logic [11:0] addr, input logic [15:0] d);
    ld_a_en = 1'b1; ld_addr = addr; ld_a_data = d;
    @(posedge clk); #1 ld_a_en = 1'b0;
  endtask

  task automatic load_b(input logic [11:0] addr, input logic [31:0] d);
    ld_b_en = 1'b1; ld_addr = addr; ld_b_data = d;
    @(posedge clk); #1 ld_b_en = 1'b0;
  endtask

  task automatic begin_reset();
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic end_reset();
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic run_until_halt(input string nm, input int bound);
    int k = 0;
    while (!a_halted && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk(nm, a_halted, 1'b1);
  endtask

  typedef struct {
    string       nm;
    logic [3:0]  op;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [3:0]  t;
    int          wt;
    logic [15:0] exp;
    int          cpi;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int nreq;
    int k;
    vecs[0]  = '{"add",      4'h0, 4'h5, 4'hD, 4'h2, 0, 16'h0002, 4};
    vecs[1]  = '{"sub",      4'h1, 4'hD, 4'h5, 4'h2, 0, 16'hFFF8, 4};
    vecs[2]  = '{"and_w2",   4'h2, 4'h7, 4'hE, 4'h2, 2, 16'h0006, 6};
    vecs[3]  = '{"or",       4'h3, 4'h5, 4'h8, 4'h2, 0, 16'hFFFD, 4};
    vecs[4]  = '{"xor",      4'h4, 4'hF, 4'h6, 4'h2, 0, 16'hFFF9, 4};
    vecs[5]  = '{"sll4",     4'h5, 4'hD, 4'h0, 4'h4, 0, 16'hFFD0, 4};
    vecs[6]  = '{"sll15",    4'h5, 4'h7, 4'h0, 4'hF, 0, 16'h8000, 4};
    vecs[7]  = '{"srl4",     4'h6, 4'hD, 4'h0, 4'h4, 0, 16'h0FFF, 4};
    vecs[8]  = '{"srl0",     4'h6, 4'hD, 4'h0, 4'h0, 0, 16'hFFFD, 4};
    vecs[9]  = '{"addi_m1",  4'h7, 4'h0, 4'h0, 4'hF, 0, 16'hFFFF, 4};
    vecs[10] = '{"addi_m8",  4'h7, 4'h8, 4'h0, 4'h8, 0, 16'hFFF0, 4};
    vecs[11] = '{"add_wrap", 4'h0, 4'hF, 4'hF, 4'h2, 1, 16'hFFFE, 5};
    vecs[12] = '{"nop_c",    4'hC, 4'h1, 4'h1, 4'h2, 0, 16'h0000, 3};
    vecs[13] = '{"nop_e_w1", 4'hE, 4'h1, 4'h1, 4'h2, 1, 16'h0000, 4};

    // Reset, first fetch and HALT behaviour; the 32-bit core's program is loaded too
    begin_reset();
    load_a(12'h010, 16'hF000);
    load_b(12'h100, 32'h0000710F);
    load_b(12'h101, 32'h00006214);
    load_b(12'h102, 32'h00000011);
    load_b(12'h103, 32'h00009105);
    load_b(12'h104, 32'h00009206);
    load_b(12'h105, 32'h00009007);
    load_b(12'h106, 32'h0000F000);
    load_b(12'h007, 32'hDEADBEEF);
    end_reset();
    @(negedge clk);
    chk("rst_pc", a_pc, 16'h0010);
    chk("rst_req", a_req, 1'b1);
    chk("rst_addr", a_addr, 16'h0010);
    chk("rst_we", a_we, 1'b0);
    chk("rst_wdata", a_wdata, 16'h0000);
    chk("rst_retire", a_retire, 1'b0);
    chk("rst_halted", a_halted, 1'b0);
    run_until_halt("halt_reached", 50);
    chk("halt_entry_retire", a_retire, 1'b1);
    nreq = 0;
    repeat (20) begin
      @(negedge clk);
      if (a_req) nreq++;
    end
    chk("halt_no_req", nreq, 0);
    chk("halt_stays", a_halted, 1'b1);
    chk("halt_retire_once", ret_q.size(), 1);

    // Table-driven ALU/NOP vectors: ADDI R1; ADDI R2; OP R3,R1,R2/imm; SW R3,[R0+7]; HALT
    foreach (vecs[i]) begin
      begin_reset();
      wait_cfg = vecs[i].wt;
      load_a(12'h010, {4'h7, 4'h1, 4'h0, vecs[i].a});
      load_a(12'h011, {4'h7, 4'h2, 4'h0, vecs[i].b});
      load_a(12'h012, {vecs[i].op, 4'h3, 4'h1, vecs[i].t});
      load_a(12'h013, 16'h9307);
      load_a(12'h014, 16'hF000);
      load_a(12'h007, 16'hDEAD);
      end_reset();
      run_until_halt({vecs[i].nm, "_halt"}, 300);
      repeat (2) @(negedge clk);
      chk({vecs[i].nm, "_result"}, mem_a[7], vecs[i].exp);
      chk_ret_gap({vecs[i].nm, "_cpi"}, 2, vecs[i].cpi);
      chk({vecs[i].nm, "_retires"}, ret_q.size(), 5);
    end

    // Store then load with one wait state on every request
    begin_reset();
    wait_cfg = 1;
    load_a(12'h010, 16'h7302);
    load_a(12'h011, 16'h9307);
    load_a(12'h012, 16'h8507);
    load_a(12'h013, 16'h9506);
    load_a(12'h014, 16'hF000);
    load_a(12'h007, 16'h0000);
    load_a(12'h006, 16'hDEAD);
    end_reset();
    k = 0;
    while (!(a_req && a_we) && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("sw_addr", a_addr, 16'h0007);
    chk("sw_wdata", a_wdata, 16'h0002);
    chk("sw_stalled", a_ready, 1'b0);
    @(negedge clk);
    chk("sw_addr_hold", a_addr, 16'h0007);
    chk("sw_wdata_hold", a_wdata, 16'h0002);
    chk("sw_we_hold", a_we, 1'b1);
    chk("sw_ready", a_ready, 1'b1);
    run_until_halt("ls_halt", 300);
    repeat (2) @(negedge clk);
    chk("sw_mem", mem_a[7], 16'h0002);
    chk("lw_result", mem_a[6], 16'h0002);
    chk_ret_gap("sw_cpi", 1, 6);
    chk_ret_gap("lw_cpi", 2, 7);

    // Branch taken, jump, branch not taken
    begin_reset();
    wait_cfg = 0;
    load_a(12'h010, 16'h7105);
    load_a(12'h011, 16'hB004);
    load_a(12'h004, 16'hA112);
    load_a(12'h005, 16'h7601);
    load_a(12'h006, 16'h7601);
    load_a(12'h007, 16'hB123);
    load_a(12'h123, 16'hA103);
    load_a(12'h124, 16'h9105);
    load_a(12'h125, 16'hF000);
    load_a(12'h127, 16'hF000);
    load_a(12'h005, 16'h7601);
    load_a(12'h000, 16'h0000);
    end_reset();
    run_until_halt("br_halt", 300);
    repeat (2) @(negedge clk);
    chk_fetch("br_f2_jmp", 2, 16'h0004);
    chk_fetch("br_f3_beq_taken", 3, 16'h0007);
    chk_fetch("br_f4_jmp123", 4, 16'h0123);
    chk_fetch("br_f5_not_taken", 5, 16'h0124);
    chk_fetch("br_f6", 6, 16'h0125);
    chk("br_store", mem_a[5], 16'h0005);
    chk_ret_gap("beq_cpi", 2, 3);
    chk_ret_gap("jmp_cpi", 3, 3);

    // Backward branch from 0x0000 to 0xFFFF, then PC+1 wraps to 0x0000
    begin_reset();
    load_a(12'h010, 16'hB000);
    load_a(12'h000, 16'hA00E);
    load_a(12'hFFF, 16'h7103);
    end_reset();
    repeat (20) @(negedge clk);
    chk_fetch("wrap_f1", 1, 16'h0000);
    chk_fetch("wrap_f2", 2, 16'hFFFF);
    chk_fetch("wrap_f3", 3, 16'h0000);

    // BEQ with simm=-1 loops on itself
    begin_reset();
    load_a(12'h010, 16'hA00F);
    end_reset();
    repeat (12) @(negedge clk);
    chk_fetch("selfloop_f1", 1, 16'h0010);
    chk_fetch("selfloop_f2", 2, 16'h0010);

    // Reset during a stalled LW data request
    begin_reset();
    wait_cfg = 3;
    load_a(12'h010, 16'h7504);
    load_a(12'h011, 16'h8507);
    load_a(12'h007, 16'h1234);
    end_reset();
    k = 0;
    while (!(a_req && !a_we && a_addr == 16'h0007) && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("abort_stalled", a_ready, 1'b0);
    chk("abort_pre_retires", ret_q.size(), 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_pc", a_pc, 16'h0010);
    chk("abort_req", a_req, 1'b1);
    chk("abort_addr", a_addr, 16'h0010);
    chk("abort_retire", a_retire, 1'b0);
    wait_cfg = 0;
    #1;
    load_a(12'h010, 16'h9506);
    load_a(12'h011, 16'hF000);
    load_a(12'h006, 16'hDEAD);
    end_reset();
    run_until_halt("abort_halt", 100);
    repeat (2) @(negedge clk);
    chk("abort_rd_untouched", mem_a[6], 16'h0000);

    // 32-bit core results (its program reruns after every shared reset)
    repeat (40) @(negedge clk);
    chk("w32_halted", b_halted, 1'b1);
    chk("w32_addi_m1", mem_b[5], 32'hFFFFFFFF);
    chk("w32_srl4", mem_b[6], 32'h0FFFFFFF);
    chk("w32_r0_zero", mem_b[7], 32'h00000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
